// File: rtl/ram_local_burst_master.sv
// ram_local_burst_master
//
// Buffers a 32-bit sample stream in a small write FIFO. It drains the FIFO
// to a memory controller local interface as fixed-length write bursts. It
// also accepts single read-back commands and forwards the returned data.
//
// Handshake semantics (all streams): a transfer happens on a phy_clk edge
// where the producer's valid and the consumer's ready are both high. The
// producer must hold the payload stable while valid is high and ready is
// low. For the controller side, local_write_req/local_read_req act as valid
// and local_ready as ready.
//
// Ports
//   phy_clk, reset          single clock, synchronous active-high reset
//   s_data/s_valid/s_ready  sample stream into the write FIFO
//   flush                   request that a partial burst be written
//   rd_cmd_*                read-back command (address, size 1..4)
//   rd_data/rd_data_valid   read-back data, one cycle after local_rdata_valid
//   wr_addr                 address of the next write burst
//   busy                    FSM is not in IDLE
//   local_*                 controller request/response signals
//   dbg_state, dbg_level, dbg_flush_pending   internal state for checkers
module ram_local_burst_master #(
  parameter int          BURST_LEN     = 4,
  parameter int          FIFO_DEPTH    = 8,
  parameter int unsigned WR_ADDR_LIMIT = 25'h1000000
) (
  input  logic                              phy_clk,
  input  logic                              reset,
  input  logic [31:0]                       s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic                              flush,
  input  logic                              rd_cmd_valid,
  output logic                              rd_cmd_ready,
  input  logic [24:0]                       rd_cmd_addr,
  input  logic [2:0]                        rd_cmd_size,
  output logic [31:0]                       rd_data,
  output logic                              rd_data_valid,
  output logic [24:0]                       wr_addr,
  output logic                              busy,
  output logic [24:0]                       local_address,
  output logic                              local_write_req,
  output logic                              local_read_req,
  output logic                              local_burstbegin,
  output logic [2:0]                        local_size,
  output logic [31:0]                       local_wdata,
  output logic [3:0]                        local_be,
  input  logic                              local_ready,
  input  logic [31:0]                       local_rdata,
  input  logic                              local_rdata_valid,
  input  logic                              local_init_done,
  output logic [1:0]                        dbg_state,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   dbg_level,
  output logic                              dbg_flush_pending
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [2:0]       BURST_N   = 3'(BURST_LEN);
  localparam logic [25:0]      ADDR_LIM  = 26'(WR_ADDR_LIMIT);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR_BURST = 2'd1;
  localparam logic [1:0] S_RD_CMD   = 2'd2;
  localparam logic [1:0] S_RD_WAIT  = 2'd3;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [24:0]      wr_addr_q, wr_addr_d;
  logic             flush_pending_q, flush_pending_d;
  logic [2:0]       wr_n_q, wr_n_d;
  logic [2:0]       wr_beat_q, wr_beat_d;
  logic             wr_from_flush_q, wr_from_flush_d;
  logic [2:0]       rd_size_q, rd_size_d;
  logic [2:0]       rd_beat_q, rd_beat_d;
  logic [24:0]      local_address_q, local_address_d;
  logic [2:0]       local_size_q, local_size_d;
  logic             local_write_req_q, local_write_req_d;
  logic             local_read_req_q, local_read_req_d;
  logic             local_burstbegin_q, local_burstbegin_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_data_valid_q, rd_data_valid_d;
  // Keeps s_ready low on the cycle right after reset.
  logic             ready_en_q, ready_en_d;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic        push;
  logic        pop;
  logic        wr_eligible;
  logic [2:0]  launch_n;
  logic [2:0]  rd_size_eff;
  logic [25:0] wr_addr_sum;

  assign s_ready = ready_en_q & (level_q < FULL_LVL);
  assign push    = s_valid & s_ready;
  assign pop     = (state_q == S_WR_BURST) & local_ready;

  assign wr_eligible = local_init_done &
                       ((level_q >= BURST_LVL) |
                        (flush_pending_q & (level_q != '0)));

  // A partial burst only happens when level < BURST_LEN <= 4, so the low
  // three bits of the level carry the full count.
  assign launch_n = (level_q >= BURST_LVL) ? BURST_N : 3'(level_q);

  // A zero size is treated as one so the read always terminates.
  assign rd_size_eff = (rd_cmd_size == 3'd0) ? 3'd1 : rd_cmd_size;

  assign wr_addr_sum = {1'b0, wr_addr_q} + 26'(wr_n_q);

  // Writes win over reads; the command is only taken from IDLE, so the
  // ready pulse lasts exactly one cycle.
  assign rd_cmd_ready = ready_en_q & (state_q == S_IDLE) & local_init_done &
                        ~wr_eligible & rd_cmd_valid;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d            = state_q;
    level_d            = level_q;
    wr_ptr_d           = wr_ptr_q;
    rd_ptr_d           = rd_ptr_q;
    wr_addr_d          = wr_addr_q;
    flush_pending_d    = flush_pending_q;
    wr_n_d             = wr_n_q;
    wr_beat_d          = wr_beat_q;
    wr_from_flush_d    = wr_from_flush_q;
    rd_size_d          = rd_size_q;
    rd_beat_d          = rd_beat_q;
    local_address_d    = local_address_q;
    local_size_d       = local_size_q;
    local_write_req_d  = local_write_req_q;
    local_read_req_d   = local_read_req_q;
    local_burstbegin_d = local_burstbegin_q;
    rd_data_d          = rd_data_q;
    rd_data_valid_d    = 1'b0;
    ready_en_d         = 1'b1;

    // FIFO bookkeeping, independent of the FSM state.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (wr_eligible) begin
          state_d            = S_WR_BURST;
          wr_n_d             = launch_n;
          wr_beat_d          = 3'd0;
          // Only a short burst is "the flush burst"; full bursts leave the
          // pending flush for whatever remains afterwards.
          wr_from_flush_d    = flush_pending_q & (level_q < BURST_LVL);
          local_address_d    = wr_addr_q;
          local_size_d       = launch_n;
          local_write_req_d  = 1'b1;
          local_burstbegin_d = 1'b1;
        end else if (rd_cmd_ready) begin
          state_d            = S_RD_CMD;
          rd_size_d          = rd_size_eff;
          rd_beat_d          = 3'd0;
          local_address_d    = rd_cmd_addr;
          local_size_d       = rd_size_eff;
          local_read_req_d   = 1'b1;
          local_burstbegin_d = 1'b1;
        end
      end

      S_WR_BURST: begin
        if (local_ready) begin
          local_burstbegin_d = 1'b0;
          wr_beat_d          = wr_beat_q + 3'd1;
          if (wr_beat_q == wr_n_q - 3'd1) begin
            state_d           = S_IDLE;
            local_write_req_d = 1'b0;
            wr_addr_d         = (wr_addr_sum >= ADDR_LIM) ? 25'd0 : wr_addr_sum[24:0];
            if (wr_from_flush_q) begin
              flush_pending_d = 1'b0;
            end
          end
        end
      end

      S_RD_CMD: begin
        if (local_ready) begin
          state_d            = S_RD_WAIT;
          local_read_req_d   = 1'b0;
          local_burstbegin_d = 1'b0;
        end
      end

      S_RD_WAIT: begin
        if (local_rdata_valid) begin
          rd_data_d       = local_rdata;
          rd_data_valid_d = 1'b1;
          rd_beat_d       = rd_beat_q + 3'd1;
          if (rd_beat_q == rd_size_q - 3'd1) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A flush with nothing buffered is simply dropped. An idle block with
    // an empty FIFO has nothing left to flush either.
    if (flush) begin
      flush_pending_d = (level_q != '0);
    end else if ((state_q == S_IDLE) && (level_q == '0)) begin
      flush_pending_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state_q            <= S_IDLE;
      level_q            <= '0;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      wr_addr_q          <= '0;
      flush_pending_q    <= 1'b0;
      wr_n_q             <= 3'd0;
      wr_beat_q          <= 3'd0;
      wr_from_flush_q    <= 1'b0;
      rd_size_q          <= 3'd0;
      rd_beat_q          <= 3'd0;
      local_address_q    <= '0;
      local_size_q       <= 3'd0;
      local_write_req_q  <= 1'b0;
      local_read_req_q   <= 1'b0;
      local_burstbegin_q <= 1'b0;
      rd_data_q          <= '0;
      rd_data_valid_q    <= 1'b0;
      ready_en_q         <= 1'b0;
    end else begin
      state_q            <= state_d;
      level_q            <= level_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      wr_addr_q          <= wr_addr_d;
      flush_pending_q    <= flush_pending_d;
      wr_n_q             <= wr_n_d;
      wr_beat_q          <= wr_beat_d;
      wr_from_flush_q    <= wr_from_flush_d;
      rd_size_q          <= rd_size_d;
      rd_beat_q          <= rd_beat_d;
      local_address_q    <= local_address_d;
      local_size_q       <= local_size_d;
      local_write_req_q  <= local_write_req_d;
      local_read_req_q   <= local_read_req_d;
      local_burstbegin_q <= local_burstbegin_d;
      rd_data_q          <= rd_data_d;
      rd_data_valid_q    <= rd_data_valid_d;
      ready_en_q         <= ready_en_d;
    end
  end

  // FIFO storage needs no reset: the pointers and level define its content.
  always_ff @(posedge phy_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign wr_addr           = wr_addr_q;
  assign busy              = (state_q != S_IDLE);
  assign local_address     = local_address_q;
  assign local_size        = local_size_q;
  assign local_write_req   = local_write_req_q;
  assign local_read_req    = local_read_req_q;
  assign local_burstbegin  = local_burstbegin_q;
  // The head only moves on an accepted beat, so wdata is stable while the
  // controller stalls.
  assign local_wdata       = local_write_req_q ? mem_q[rd_ptr_q] : 32'd0;
  assign local_be          = local_write_req_q ? 4'hF : 4'h0;
  assign rd_data           = rd_data_q;
  assign rd_data_valid     = rd_data_valid_q;
  assign dbg_state         = state_q;
  assign dbg_level         = level_q;
  assign dbg_flush_pending = flush_pending_q;

endmodule
